next_pc_sequencer: RTL and testbench
====================================

// Module: next_pc_sequencer
// PURPOSE
//  Registered, parametrised next-PC unit for the MIPS datapath. Holds the PC,
//  resolves six branch conditions, jump, jr and exception redirects, and
//  handles boot delay, stall and halt/resume. Sits between the register file
//  and instruction memory. Fetch sees a word-aligned PC each cycle it is valid.
// PARAMETERS
//  N          32        data width of rs/rt; PC word-address width PW = N-2
//  RESET_VEC  0         PW-bit word address loaded on reset
//  EXC_VEC    'h20      PW-bit word address for exceptions and misaligned jr
//  BOOT_CYC   4         cycles held in BOOT after reset release (>=1)
//  CNT_W      16        width of the saturating taken-branch counter
// PORTS
//  clk          in   1     rising-edge clock
//  rst_n        in   1     asynchronous active-low reset
//  rs, rt       in   N     register operands, signed two's complement
//  jta          in   26    instr[25:0]; imm16 = jta[15:0]
//  pc_src       in   2     0 seq/branch, 1 jump, 2 jr, 3 exception
//  br_type      in   3     0 none,1 beq,2 bne,3 bltz,4 bgez,5 blez,6 bgtz,7 none
//  instr_valid  in   1     decode fields valid for current pc
//  stall        in   1     hold PC this cycle
//  halt         in   1     enter HALT at next advance
//  resume       in   1     leave HALT
//  pc           out  PW    current PC (word address)
//  pc_valid     out  1     pc is valid for fetch
//  inc_pc       out  PW    pc+1; this is also the jal link address
//  br_taken     out  1     combinational: branch condition true this cycle
//  misalign     out  1     one-cycle pulse: jr taken with rs[1:0]!=0
//  taken_cnt    out  CNT_W saturating count of taken branches and jumps
// BEHAVIOUR
//  Reset (async, rst_n=0) sets these values:
//   - pc=RESET_VEC, state=BOOT, boot counter=0, taken_cnt=0.
//   - pc_valid=0, misalign=0.
//  FSM states: BOOT, RUN, HALT.
//   - BOOT: counts BOOT_CYC cycles, then moves to RUN. pc_valid=0 and pc holds.
//   - RUN: pc_valid=1. PC advances when instr_valid=1 and stall=0.
//     If instr_valid=0 or stall=1, PC holds and no counter or flag changes.
//   - RUN->HALT on an advance with halt=1. The PC still takes that advance.
//   - HALT: pc_valid=0 and PC holds. HALT->RUN on resume=1.
//     resume takes effect the cycle after it is sampled.
//  Next-PC selection, in priority order:
//   1. pc_src=3 -> EXC_VEC.
//   2. pc_src=2 -> rs[N-1:2]. If rs[1:0]!=0: EXC_VEC instead, and misalign
//      is pulsed the next cycle.
//   3. pc_src=1 -> {inc_pc[PW-1:26], jta}. Upper bits come from pc+1.
//   4. pc_src=0 with br_taken -> inc_pc + sext(imm16), mod 2^PW.
//   5. Otherwise -> inc_pc.
//  Branch conditions (signed compares):
//   - beq: rs==rt. bne: rs!=rt.
//   - bltz: rs<0. bgez: rs>=0. blez: rs<=0. bgtz: rs>0.
//   - br_taken is forced to 0 when pc_src!=0.
//  Wrap-around: inc_pc of all-ones is 0. The branch sum drops the carry.
//  taken_cnt increments on every advance that redirects through path 2-4,
//  including a misaligned jr. It saturates at 2^CNT_W-1 and never wraps.
//  stall takes precedence over halt. halt is ignored outside RUN.
//  rst_n asserted mid-operation: every register returns to its reset value
//  immediately. BOOT is re-run on release.
//  Latency: a redirect decided in cycle t appears on pc in cycle t+1.
// TESTING
//  - Reset, BOOT_CYC=4: pc_valid is 0 for 4 cycles, then 1 with pc=0.
//    With pc_src=0 and br_type=0, pc counts 0,1,2,...
//  - pc=0x10, beq, rs=rt=5, imm16=0xFFFE: next pc=0x0F, br_taken=1,
//    taken_cnt=1. Same case with rt=6: next pc=0x11.
//  - bltz with rs=0x80000000: taken. bgtz with rs=0: not taken.
//    blez with rs=0: taken.
//  - pc=0x3FFFFFFF, j, jta=0x0000123: pc becomes 0x00000123
//    (upper bits taken from inc_pc=0).
//  - jr with rs=0x00000102: pc=EXC_VEC (0x20) and misalign pulses 1 cycle.
//    jr with rs=0x400: pc=0x100.
//  - halt during stall: PC holds and stays in RUN. halt without stall:
//    pc advances once, then pc_valid=0 until resume. rst_n pulsed low
//    mid-run: pc=RESET_VEC and taken_cnt=0 at once.

Source files
------------

// File: rtl/next_pc_sequencer.sv
// next_pc_sequencer: registered next-PC unit for the MIPS datapath.
// Holds the word-addressed PC and resolves branch, jump, jr and exception
// redirects. It also handles the post-reset boot delay, stalls, and halt/resume.

module next_pc_sequencer #(
    parameter int N         = 32,
    parameter int RESET_VEC = 0,
    parameter int EXC_VEC   = 'h20,
    parameter int BOOT_CYC  = 4,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       rs,
    input  logic [N-1:0]       rt,
    input  logic [25:0]        jta,
    input  logic [1:0]         pc_src,
    input  logic [2:0]         br_type,
    input  logic               instr_valid,
    input  logic               stall,
    input  logic               halt,
    input  logic               resume,
    output logic [N-3:0]       pc,
    output logic               pc_valid,
    output logic [N-3:0]       inc_pc,
    output logic               br_taken,
    output logic               misalign,
    output logic [CNT_W-1:0]   taken_cnt
);

    localparam int PW = N - 2;
    localparam int BW = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

    state_t             r_state, w_state_next;
    logic [BW-1:0]      r_boot_cnt, w_boot_next;
    logic [PW-1:0]      r_pc, w_target;
    logic [CNT_W-1:0]   r_taken_cnt;
    logic               r_misalign;
    logic               w_advance, w_redirect, w_misalign_set, w_cond;
    logic [PW-1:0]      w_inc_pc, w_imm_sext;
    logic signed [N-1:0] w_rs_s, w_rt_s;

    assign w_inc_pc   = r_pc + PW'(1);
    assign w_imm_sext = {{(PW-16){jta[15]}}, jta[15:0]};
    assign w_rs_s     = $signed(rs);
    assign w_rt_s     = $signed(rt);

    // Branch condition from br_type; only meaningful on the seq/branch path.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        w_cond = 1'b0;
        case (br_type)
            3'd1:    w_cond = (w_rs_s == w_rt_s);
            3'd2:    w_cond = (w_rs_s != w_rt_s);
            3'd3:    w_cond = (w_rs_s <  0);
            3'd4:    w_cond = (w_rs_s >= 0);
            3'd5:    w_cond = (w_rs_s <= 0);
            3'd6:    w_cond = (w_rs_s >  0);
            default: w_cond = 1'b0;
        endcase
    end

    assign br_taken = (pc_src == 2'd0) && w_cond;

    // Next-PC selection in priority order: exception, jr, jump, branch, sequential.
    always_comb begin
        w_target       = w_inc_pc;
        w_redirect     = 1'b0;
        w_misalign_set = 1'b0;
        case (pc_src)
            2'd3: w_target = PW'(EXC_VEC);
            2'd2: begin
                w_redirect = 1'b1;
                if (rs[1:0] != 2'b00) begin
                    w_target       = PW'(EXC_VEC);
                    w_misalign_set = 1'b1;
                end else begin
                    w_target = rs[N-1:2];
                end
            end
            2'd1: begin
                w_redirect = 1'b1;
                w_target   = {w_inc_pc[PW-1:26], jta};
            end
            default: begin
                if (br_taken) begin
                    w_redirect = 1'b1;
                    w_target   = w_inc_pc + w_imm_sext;
                end
            end
        endcase
    end

    // Sequencer FSM next-state: boot countdown, run/halt transitions.
    always_comb begin
        w_state_next = r_state;
        w_boot_next  = r_boot_cnt;
        w_advance    = 1'b0;
        case (r_state)
            S_BOOT: begin
                if (r_boot_cnt == BW'(BOOT_CYC - 1)) begin
                    w_state_next = S_RUN;
                    w_boot_next  = '0;
                end else begin
                    w_boot_next = r_boot_cnt + BW'(1);
                end
            end
            S_RUN: begin
                w_advance = instr_valid && !stall;
                if (w_advance && halt)
                    w_state_next = S_HALT;
            end
            S_HALT: begin
                if (resume)
                    w_state_next = S_RUN;
            end
            default: w_state_next = S_BOOT;
        endcase
    end

    // State, PC, counter and misalign flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state     <= S_BOOT;
            r_boot_cnt  <= '0;
            r_pc        <= PW'(RESET_VEC);
            r_taken_cnt <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_boot_cnt <= w_boot_next;
            r_misalign <= w_advance && w_misalign_set;
            if (w_advance) begin
                r_pc <= w_target;
                if (w_redirect && (r_taken_cnt != {CNT_W{1'b1}}))
                    r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
        end
    end

    assign pc        = r_pc;
    assign inc_pc    = w_inc_pc;
    assign pc_valid  = (r_state == S_RUN);
    assign misalign  = r_misalign;
    assign taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_next_pc_sequencer.sv
// Testbench for next_pc_sequencer: directed cases plus randomized traffic,
// checked against a cycle-level behavioural model of the PC unit.

module tb_next_pc_sequencer;

    localparam int  CNT_W    = 4;
    localparam int  BOOT_CYC = 4;
    localparam longint PMASK = (64'd1 << 30) - 1;
    localparam longint CMAX  = (64'd1 << CNT_W) - 1;
    localparam longint EXC   = 'h20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rs = '0, rt = '0;
    logic [25:0] jta = '0;
    logic [1:0]  pc_src = '0;
    logic [2:0]  br_type = '0;
    logic        instr_valid = 1'b0, stall = 1'b0, halt = 1'b0, resume = 1'b0;
    logic [29:0] pc, inc_pc;
    logic        pc_valid, br_taken, misalign;
    logic [CNT_W-1:0] taken_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: mode 0 boot, 1 run, 2 halt.
    int     m_mode;
    int     m_boot;
    longint m_pc;
    longint m_cnt;
    bit     m_mis;

    next_pc_sequencer #(.N(32), .RESET_VEC(0), .EXC_VEC('h20),
                        .BOOT_CYC(BOOT_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .jta(jta),
        .pc_src(pc_src), .br_type(br_type), .instr_valid(instr_valid),
        .stall(stall), .halt(halt), .resume(resume), .pc(pc),
        .pc_valid(pc_valid), .inc_pc(inc_pc), .br_taken(br_taken),
        .misalign(misalign), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_taken(input logic [1:0] src, input logic [2:0] bt,
                                       input logic [31:0] a_u, input logic [31:0] b_u);
        int a, b;
        a = a_u;
        b = b_u;
        if (src != 2'd0) return 1'b0;
        case (bt)
            3'd1: return a == b;
            3'd2: return a != b;
            3'd3: return a < 0;
            3'd4: return a >= 0;
            3'd5: return a <= 0;
            3'd6: return a > 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_boot = 0; m_pc = 0; m_cnt = 0; m_mis = 0;
    endtask

    // One clock edge of the reference behaviour, using current inputs.
    task automatic model_step();
        longint inc, nxt, off;
        bit redir, mis_n;
        mis_n = 0;
        if (m_mode == 0) begin
            m_boot++;
            if (m_boot == BOOT_CYC) m_mode = 1;
        end else if (m_mode == 1) begin
            if (instr_valid && !stall) begin
                inc   = (m_pc + 1) & PMASK;
                nxt   = inc;
                redir = 0;
                if (pc_src == 2'd3) nxt = EXC;
                else if (pc_src == 2'd2) begin
                    redir = 1;
                    if (rs % 4 != 0) begin nxt = EXC; mis_n = 1; end
                    else nxt = longint'(rs) / 4;
                end else if (pc_src == 2'd1) begin
                    redir = 1;
                    nxt = (inc & ~((64'd1 << 26) - 1)) | longint'(jta);
                end else if (model_taken(pc_src, br_type, rs, rt)) begin
                    redir = 1;
                    off = longint'($signed(jta[15:0]));
                    nxt = (inc + off) & PMASK;
                end
                m_pc = nxt;
                if (redir && m_cnt < CMAX) m_cnt++;
                if (halt) m_mode = 2;
            end
        end else if (resume) begin
            m_mode = 1;
        end
        m_mis = mis_n;
    endtask

    // Compare all outputs with the model, then clock once (ends at negedge).
    task automatic do_cycle();
        #1;
        check("pc", longint'(pc), m_pc);
        check("pc_valid", longint'(pc_valid), longint'(m_mode == 1));
        check("inc_pc", longint'(inc_pc), (m_pc + 1) & PMASK);
        check("br_taken", longint'(br_taken), longint'(model_taken(pc_src, br_type, rs, rt)));
        check("misalign", longint'(misalign), longint'(m_mis));
        check("taken_cnt", longint'(taken_cnt), m_cnt);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_pc", longint'(pc), 0);
        check("rst_cnt", longint'(taken_cnt), 0);
        check("rst_valid", longint'(pc_valid), 0);
        check("rst_misalign", longint'(misalign), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_in(input logic [1:0] src, input logic [2:0] bt,
                          input logic [31:0] a, input logic [31:0] b, input logic [25:0] j);
        pc_src = src; br_type = bt; rs = a; rt = b; jta = j;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(4))
            0: return 32'd0;
            1: return 32'd5;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        longint prev, prev_cnt;
        model_reset();
        @(negedge clk);
        apply_reset();
        instr_valid = 1'b1;
        set_in(2'd0, 3'd0, 0, 0, 0);

        // Boot: four cycles invalid, then counting from 0.
        repeat (BOOT_CYC) do_cycle();
        check("boot_done_valid", longint'(pc_valid), 1);
        check("boot_done_pc", longint'(pc), 0);
        repeat (3) do_cycle();
        check("seq_pc", longint'(pc), 3);

        // beq taken backwards from 0x10, then not taken.
        set_in(2'd2, 3'd0, 32'h40, 0, 0); do_cycle();
        check("jr_to_10", longint'(pc), 'h10);
        prev_cnt = longint'(taken_cnt);
        set_in(2'd0, 3'd1, 5, 5, 26'hFFFE);
        #1 check("beq_taken", longint'(br_taken), 1);
        do_cycle();
        check("beq_pc", longint'(pc), 'h0F);
        check("beq_cnt", longint'(taken_cnt), prev_cnt + 1);
        set_in(2'd2, 3'd0, 32'h40, 0, 0); do_cycle();
        set_in(2'd0, 3'd1, 5, 6, 26'hFFFE); do_cycle();
        check("beq_not_pc", longint'(pc), 'h11);

        // Signed conditions, observed while stalled.
        stall = 1'b1;
        set_in(2'd0, 3'd3, 32'h8000_0000, 0, 0); #1 check("bltz_min", longint'(br_taken), 1); do_cycle();
        set_in(2'd0, 3'd6, 0, 0, 0); #1 check("bgtz_zero", longint'(br_taken), 0); do_cycle();
        set_in(2'd0, 3'd5, 0, 0, 0); #1 check("blez_zero", longint'(br_taken), 1); do_cycle();
        set_in(2'd1, 3'd5, 0, 0, 0); #1 check("br_gated", longint'(br_taken), 0); do_cycle();
        stall = 1'b0;

        // Jump with wrap of inc_pc upper bits.
        set_in(2'd2, 3'd0, 32'hFFFF_FFFC, 0, 0); do_cycle();
        check("pc_top", longint'(pc), 'h3FFF_FFFF);
        check("inc_wrap", longint'(inc_pc), 0);
        set_in(2'd1, 3'd0, 0, 0, 26'h123); do_cycle();
        check("j_pc", longint'(pc), 'h123);

        // Misaligned jr, then aligned jr.
        set_in(2'd2, 3'd0, 32'h102, 0, 0); do_cycle();
        check("jr_mis_pc", longint'(pc), 'h20);
        check("jr_mis_flag", longint'(misalign), 1);
        set_in(2'd2, 3'd0, 32'h400, 0, 0); do_cycle();
        check("jr_pc", longint'(pc), 'h100);
        check("jr_mis_clear", longint'(misalign), 0);

        // Halt under stall is ignored; halt without stall advances once.
        set_in(2'd0, 3'd0, 0, 0, 0);
        halt = 1'b1; stall = 1'b1; prev = longint'(pc); do_cycle();
        check("halt_stall_pc", longint'(pc), prev);
        check("halt_stall_valid", longint'(pc_valid), 1);
        stall = 1'b0; do_cycle();
        check("halt_pc", longint'(pc), prev + 1);
        check("halt_valid", longint'(pc_valid), 0);
        halt = 1'b0; repeat (3) do_cycle();
        check("halt_hold", longint'(pc), prev + 1);
        resume = 1'b1; do_cycle(); resume = 1'b0;
        check("resume_valid", longint'(pc_valid), 1);

        // Counter saturation.
        set_in(2'd1, 3'd0, 0, 0, 26'h40);
        repeat (20) do_cycle();
        check("cnt_sat", longint'(taken_cnt), CMAX);

        // Asynchronous reset mid-run, then randomized traffic.
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            set_in(2'($urandom_range(3)), 3'($urandom_range(7)), pick_val(),
                   ($urandom_range(1) == 0) ? rs : pick_val(), 26'($urandom));
            if ($urandom_range(1) == 0) rt = rs;
            instr_valid = ($urandom_range(9) != 0);
            stall       = ($urandom_range(4) == 0);
            halt        = ($urandom_range(19) == 0);
            resume      = ($urandom_range(3) == 0);
            if ($urandom_range(299) == 0) apply_reset();
            do_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
